// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths and the control bundle that travels from decode to execute.
// Both the pipeline register and its interface import this package.
package id_ex_pipe_reg_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 4;
  localparam int COND_W      = 4;
  localparam int FLAGS_W     = 4;
  localparam int FLAGWRITE_W = 2;
  localparam int ALUCTRL_W   = 2;

  // Every non-datapath field, packed so one flop_rc can hold the whole bundle.
  typedef struct packed {
    logic                   pcsrc;
    logic                   regwrite;
    logic                   memtoreg;
    logic                   memwrite;
    logic                   branch;
    logic                   alusrc;
    logic [FLAGWRITE_W-1:0] flagwrite;
    logic [ALUCTRL_W-1:0]   aluctrl;
    logic [FLAGS_W-1:0]     flags;
    logic [COND_W-1:0]      cond;
    logic [REG_ADDR_W-1:0]  wa3;
    logic [REG_ADDR_W-1:0]  ra1;
    logic [REG_ADDR_W-1:0]  ra2;
  } ctrl_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute bundle: the decode-side fields, the flush request and
// the registered execute-side fields.
interface id_ex_pipe_reg_if #(parameter int WIDTH = id_ex_pipe_reg_pkg::DATA_W);
  import id_ex_pipe_reg_pkg::*;

  logic                   clr;
  logic [WIDTH-1:0]       rd1;
  logic [WIDTH-1:0]       rd2;
  logic [WIDTH-1:0]       extImm;
  logic [REG_ADDR_W-1:0]  wa3d;
  logic                   pcsrcD;
  logic                   regwrited;
  logic                   memtoregd;
  logic                   memwrited;
  logic                   branchd;
  logic                   alusrcd;
  logic [FLAGWRITE_W-1:0] flagwrited;
  logic [ALUCTRL_W-1:0]   alucontrold;
  logic [FLAGS_W-1:0]     flagsd;
  logic [COND_W-1:0]      condd;
  logic [REG_ADDR_W-1:0]  ra1d;
  logic [REG_ADDR_W-1:0]  ra2d;

  logic [FLAGS_W-1:0]     FlagsE;
  logic [COND_W-1:0]      CondE;
  logic [FLAGWRITE_W-1:0] FlagWriteE;
  logic [ALUCTRL_W-1:0]   ALUControlE;
  logic                   PCSrcE;
  logic                   RegWriteE;
  logic                   MemWriteE;
  logic                   MemtoRegE;
  logic                   ALUSrcE;
  logic                   BranchE;
  logic [REG_ADDR_W-1:0]  WA3E;
  logic [WIDTH-1:0]       RD1;
  logic [WIDTH-1:0]       RD2;
  logic [WIDTH-1:0]       EXTIMM;
  logic [REG_ADDR_W-1:0]  RA1E;
  logic [REG_ADDR_W-1:0]  RA2E;

  modport master (
    output clr, rd1, rd2, extImm, wa3d, pcsrcD, regwrited, memtoregd,
           memwrited, branchd, alusrcd, flagwrited, alucontrold, flagsd,
           condd, ra1d, ra2d,
    input  FlagsE, CondE, FlagWriteE, ALUControlE, PCSrcE, RegWriteE,
           MemWriteE, MemtoRegE, ALUSrcE, BranchE, WA3E, RD1, RD2, EXTIMM,
           RA1E, RA2E
  );

  modport slave (
    input  clr, rd1, rd2, extImm, wa3d, pcsrcD, regwrited, memtoregd,
           memwrited, branchd, alusrcd, flagwrited, alucontrold, flagsd,
           condd, ra1d, ra2d,
    output FlagsE, CondE, FlagWriteE, ALUControlE, PCSrcE, RegWriteE,
           MemWriteE, MemtoRegE, ALUSrcE, BranchE, WA3E, RD1, RD2, EXTIMM,
           RA1E, RA2E
  );

endinterface

// File: rtl/id_ex_pipe_reg_flop_rc.sv
// Generic W-bit register with asynchronous active-high reset and a
// synchronous clear; both force the stored value to zero.
module flop_rc #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // reset wins over clr, clr wins over capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register: one flop_rc over the packed control
// bundle plus one per datapath word, so a flush zeroes everything at once.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_pipe_reg_if.slave  bus
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_e;

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.pcsrc     = bus.pcsrcD;
    ctrl_d.regwrite  = bus.regwrited;
    ctrl_d.memtoreg  = bus.memtoregd;
    ctrl_d.memwrite  = bus.memwrited;
    ctrl_d.branch    = bus.branchd;
    ctrl_d.alusrc    = bus.alusrcd;
    ctrl_d.flagwrite = bus.flagwrited;
    ctrl_d.aluctrl   = bus.alucontrold;
    ctrl_d.flags     = bus.flagsd;
    ctrl_d.cond      = bus.condd;
    ctrl_d.wa3       = bus.wa3d;
    ctrl_d.ra1       = bus.ra1d;
    ctrl_d.ra2       = bus.ra2d;
  end

  flop_rc #(.W($bits(ctrl_t))) u_ctrl (
    .clk(clk), .reset(reset), .clr(bus.clr), .d(ctrl_d), .q(ctrl_e)
  );

  flop_rc #(.W(WIDTH)) u_rd1 (
    .clk(clk), .reset(reset), .clr(bus.clr), .d(bus.rd1), .q(bus.RD1)
  );

  flop_rc #(.W(WIDTH)) u_rd2 (
    .clk(clk), .reset(reset), .clr(bus.clr), .d(bus.rd2), .q(bus.RD2)
  );

  flop_rc #(.W(WIDTH)) u_imm (
    .clk(clk), .reset(reset), .clr(bus.clr), .d(bus.extImm), .q(bus.EXTIMM)
  );

  assign bus.PCSrcE      = ctrl_e.pcsrc;
  assign bus.RegWriteE   = ctrl_e.regwrite;
  assign bus.MemtoRegE   = ctrl_e.memtoreg;
  assign bus.MemWriteE   = ctrl_e.memwrite;
  assign bus.BranchE     = ctrl_e.branch;
  assign bus.ALUSrcE     = ctrl_e.alusrc;
  assign bus.FlagWriteE  = ctrl_e.flagwrite;
  assign bus.ALUControlE = ctrl_e.aluctrl;
  assign bus.FlagsE      = ctrl_e.flags;
  assign bus.CondE       = ctrl_e.cond;
  assign bus.WA3E        = ctrl_e.wa3;
  assign bus.RA1E        = ctrl_e.ra1;
  assign bus.RA2E        = ctrl_e.ra2;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus random
// traffic, compared against a stage-level model of what execute should see.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  wa3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic [1:0]  flagwrite;
    logic [1:0]  aluctrl;
    logic        pcsrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        alusrc;
  } stage_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  stage_t expected = '0;
  int     checkCount = 0;
  int     failCount = 0;

  id_ex_pipe_reg_if #(.WIDTH(32)) bus ();

  id_ex_pipe_reg #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] want);
    checkCount++;
    if (observed !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, want);
    end
  endtask

  // Compare every execute-side field against the model's view of the stage.
  task automatic checkStage(input string tag);
    checkOutput({tag, ".RD1"},         bus.RD1,                expected.rd1);
    checkOutput({tag, ".RD2"},         bus.RD2,                expected.rd2);
    checkOutput({tag, ".EXTIMM"},      bus.EXTIMM,             expected.imm);
    checkOutput({tag, ".WA3E"},        32'(bus.WA3E),          32'(expected.wa3));
    checkOutput({tag, ".RA1E"},        32'(bus.RA1E),          32'(expected.ra1));
    checkOutput({tag, ".RA2E"},        32'(bus.RA2E),          32'(expected.ra2));
    checkOutput({tag, ".FlagsE"},      32'(bus.FlagsE),        32'(expected.flags));
    checkOutput({tag, ".CondE"},       32'(bus.CondE),         32'(expected.cond));
    checkOutput({tag, ".FlagWriteE"},  32'(bus.FlagWriteE),    32'(expected.flagwrite));
    checkOutput({tag, ".ALUControlE"}, 32'(bus.ALUControlE),   32'(expected.aluctrl));
    checkOutput({tag, ".PCSrcE"},      32'(bus.PCSrcE),        32'(expected.pcsrc));
    checkOutput({tag, ".RegWriteE"},   32'(bus.RegWriteE),     32'(expected.regwrite));
    checkOutput({tag, ".MemtoRegE"},   32'(bus.MemtoRegE),     32'(expected.memtoreg));
    checkOutput({tag, ".MemWriteE"},   32'(bus.MemWriteE),     32'(expected.memwrite));
    checkOutput({tag, ".BranchE"},     32'(bus.BranchE),       32'(expected.branch));
    checkOutput({tag, ".ALUSrcE"},     32'(bus.ALUSrcE),       32'(expected.alusrc));
  endtask

  task automatic applyStimulus(input stage_t s, input logic c);
    bus.clr         = c;
    bus.rd1         = s.rd1;
    bus.rd2         = s.rd2;
    bus.extImm      = s.imm;
    bus.wa3d        = s.wa3;
    bus.ra1d        = s.ra1;
    bus.ra2d        = s.ra2;
    bus.flagsd      = s.flags;
    bus.condd       = s.cond;
    bus.flagwrited  = s.flagwrite;
    bus.alucontrold = s.aluctrl;
    bus.pcsrcD      = s.pcsrc;
    bus.regwrited   = s.regwrite;
    bus.memtoregd   = s.memtoreg;
    bus.memwrited   = s.memwrite;
    bus.branchd     = s.branch;
    bus.alusrcd     = s.alusrc;
  endtask

  // Drive one decode-stage slot, predict what execute holds after the edge,
  // check just after the edge and return on the following falling edge.
  task automatic stepCycle(input stage_t s, input logic c, input string tag);
    applyStimulus(s, c);
    if (reset || c)
      expected = '0;
    else
      expected = s;
    @(posedge clk);
    #1;
    checkStage(tag);
    @(negedge clk);
  endtask

  function automatic stage_t randomStage();
    stage_t s;
    s.rd1       = $urandom;
    s.rd2       = $urandom;
    s.imm       = $urandom;
    s.wa3       = 4'($urandom);
    s.ra1       = 4'($urandom);
    s.ra2       = 4'($urandom);
    s.flags     = 4'($urandom);
    s.cond      = 4'($urandom);
    s.flagwrite = 2'($urandom);
    s.aluctrl   = 2'($urandom);
    s.pcsrc     = 1'($urandom);
    s.regwrite  = 1'($urandom);
    s.memtoreg  = 1'($urandom);
    s.memwrite  = 1'($urandom);
    s.branch    = 1'($urandom);
    s.alusrc    = 1'($urandom);
    return s;
  endfunction

  stage_t capVec;
  stage_t isoVec;
  stage_t onesVec;

  initial begin
    capVec = '{rd1: 32'hDEADBEEF, rd2: 32'h12345678, imm: 32'h000000FF,
               wa3: 4'hA, ra1: 4'h3, ra2: 4'hC, flags: 4'b1010, cond: 4'hE,
               flagwrite: 2'b11, aluctrl: 2'b01, pcsrc: 1'b1, regwrite: 1'b1,
               memtoreg: 1'b1, memwrite: 1'b1, branch: 1'b1, alusrc: 1'b1};
    onesVec = '1;

    applyStimulus(capVec, 1'b0);
    #1 reset = 1'b1;
    expected = '0;
    #1 checkStage("reset_pre_edge");
    repeat (2) begin
      @(posedge clk);
      #1 checkStage("reset_held");
    end
    @(negedge clk);
    reset = 1'b0;

    stepCycle(capVec, 1'b0, "capture");
    stepCycle(capVec, 1'b1, "flush");
    stepCycle(capVec, 1'b0, "after_flush");

    isoVec = '0;
    isoVec.regwrite = 1'b1;
    isoVec.memtoreg = 1'b1;
    isoVec.branch   = 1'b1;
    stepCycle(isoVec, 1'b0, "iso_regwrite");
    isoVec.regwrite = 1'b0;
    isoVec.memwrite = 1'b1;
    isoVec.memtoreg = 1'b0;
    isoVec.alusrc   = 1'b1;
    stepCycle(isoVec, 1'b0, "iso_memwrite");

    stepCycle(capVec, 1'b0, "preload");
    #2 reset = 1'b1;
    expected = '0;
    #1 checkStage("async_reset");
    @(posedge clk);
    #1 checkStage("async_held");
    @(negedge clk);
    reset = 1'b0;
    stepCycle(randomStage(), 1'b0, "post_reset_capture");

    reset = 1'b1;
    stepCycle(capVec, 1'b1, "reset_and_clr");
    reset = 1'b0;
    stepCycle(capVec, 1'b1, "clr_after_release");
    stepCycle(onesVec, 1'b0, "full_width");

    for (int i = 0; i < 40; i++)
      stepCycle(randomStage(), ($urandom_range(0, 4) == 0), "random");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Decode-to-execute (D→E) pipeline register of the ARM-style pipelined core. It captures decode-stage data (register read values, extended immediate, destination/source register addresses) and control signals on each rising clock edge, and presents them to the execute stage. A synchronous clear (flush) inserts a bubble by zeroing every stored field. An asynchronous reset also zeroes every field.

Parameters:
WIDTH, 32, datapath width of RD1/RD2/EXTIMM fields

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-high reset; zeroes all outputs
clr  in  1  synchronous flush; zeroes all outputs at next rising edge
rd1  in  WIDTH  register file read data 1 (D)
rd2  in  WIDTH  register file read data 2 (D)
extImm  in  WIDTH  extended immediate (D)
wa3d  in  4  destination register address (D)
pcsrcD  in  1  PC-source control (D)
regwrited  in  1  register write enable (D)
memtoregd  in  1  writeback-from-memory select (D)
memwrited  in  1  memory write enable (D)
branchd  in  1  branch indicator (D)
alusrcd  in  1  ALU B-operand select (D)
flagwrited  in  2  flag-write enables (D)
alucontrold  in  2  ALU operation (D)
flagsd  in  4  current NZCV flags (D)
condd  in  4  condition field (D)
ra1d  in  4  source register address 1 (D)
ra2d  in  4  source register address 2 (D)
FlagsE, CondE  out  4 each  registered flagsd, condd
FlagWriteE, ALUControlE  out  2 each  registered flagwrited, alucontrold
PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE  out  1 each  registered control bits
WA3E  out  4  registered wa3d
RD1, RD2, EXTIMM  out  WIDTH each  registered rd1, rd2, extImm
RA1E, RA2E  out  4 each  registered ra1d, ra2d

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Priority: reset > clr > capture.
- reset=1: all outputs go to 0 immediately, independent of clk; they stay 0 while reset is held.
- Rising clk edge with reset=0 and clr=1: every output becomes 0, data and control alike. The result is a bubble with no register write, no memory write, no branch and no flag write.
- Rising clk edge with reset=0 and clr=0: each output takes its corresponding input value. Latency is one cycle; there is no enable and no stall.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- clr sampled at the same edge that reset deasserts: clr takes effect and outputs stay 0.
- Reset asserted mid-stream: previous contents are lost; capture resumes at the first rising edge after deassertion.
- Widths pass through unchanged; no sign extension or arithmetic is performed.

Decomposition:
- Shared package (e.g., core_pkg): REG_ADDR_W=4, COND_W=4, FLAGS_W=4, FLAGWRITE_W=2, ALUCTRL_W=2, and default DATA_W=32.
- One generic sub-module, flop_rc #(W): W-bit flop with async active-high reset and sync clear, reset/clear value 0.
- Instantiate flop_rc once per field, or once over a concatenated control bundle plus once per data word.

Test Plan:
- Reset: hold reset=1 for 2 cycles with non-zero inputs -> all outputs 0 throughout, including before the first clk edge.
- Capture: clr=0, rd1=0xDEADBEEF, rd2=0x12345678, extImm=0x000000FF, wa3d=4'hA, ra1d=4'h3, ra2d=4'hC, flagsd=4'b1010, condd=4'hE, flagwrited=2'b11, alucontrold=2'b01, all 1-bit controls=1 -> after one rising edge every output equals its input.
- Flush: load the capture values, then clr=1 for one edge with inputs unchanged -> all outputs 0; clr=0 on the next edge -> values reappear.
- Control isolation: drive only regwrited=1 and memwrited=0, then swap the two -> RegWriteE/MemWriteE track with one-cycle latency, and MemtoRegE/ALUSrcE/BranchE stay at their inputs (check for bit-position mixups).
- Async reset mid-stream: load non-zero values, assert reset between clock edges -> outputs 0 before the next edge; deassert, apply clr=0 with new inputs -> captured at the following edge.
- Simultaneous events: reset and clr both 1 at an edge -> outputs 0; data pattern 0xFFFFFFFF on all WIDTH fields -> captured intact (full-width check).
